// File: rtl/sequence_tx_pkg.sv
// Shared definitions for the 101-sequence frame transmitter and the benches
// that drive 101 detectors.
//   tx_state_t       : FSM state, also exported on the Q debug port
//   DEFAULT_PREAMBLE : preamble marker a downstream 101 detector looks for
//   max3             : elaboration-time helper for sizing the frame counter
package sequence_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PRE  = 2'b01,
    ST_DATA = 2'b10,
    ST_GAP  = 2'b11
  } tx_state_t;

  localparam int unsigned DEFAULT_PRE_W = 3;
  localparam logic [DEFAULT_PRE_W-1:0] DEFAULT_PREAMBLE = 3'b101;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, shifting left, serial output = MSB.
//   clk   : clock, rising edge
//   clear : asynchronous active-high reset, clears contents
//   load  : capture d (takes priority over shift)
//   shift : shift left by one, zero filled
//   d     : parallel load word
//   msb   : serial output, current MSB
module piso_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/sequence_tx_101.sv
// Bit-serial frame transmitter feeding the x input of a 101 detector.
// Each accepted word goes out as: preamble (MSB-first), payload (MSB-first),
// then GAP forced-zero bits.
//   clk         : clock, rising edge
//   clear       : asynchronous active-high reset
//   data_in     : payload word, sampled on an accepted load
//   load        : send request, accepted when load && ready
//   ready       : idle, able to accept a load
//   x           : registered serial output
//   busy        : frame (including gap) in progress
//   frame_start : pulse with the first preamble bit on x
//   frame_done  : pulse with the last payload bit on x
//   Q           : state encoding, debug only
module sequence_tx_101
  import sequence_tx_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         PRE_W    = DEFAULT_PRE_W,
  parameter logic [PRE_W-1:0]    PREAMBLE = PRE_W'(DEFAULT_PREAMBLE),
  parameter int unsigned         GAP      = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              x,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done,
  output logic [1:0]        Q
);

  localparam int unsigned CW = $clog2(max3(DATA_W, PRE_W, GAP) + 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRE_W - 1);
  localparam logic [CW-1:0] CNT_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_GAP  = CW'((GAP > 0) ? GAP - 1 : 0);

  tx_state_t        state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_nxt, fs_nxt, fd_nxt;
  logic             sr_load, sr_shift, sr_msb;
  logic [PRE_W-1:0] pre_sh;

  piso_shift_reg #(
    .WIDTH (DATA_W)
  ) u_sr (
    .clk   (clk),
    .clear (clear),
    .load  (sr_load),
    .shift (sr_shift),
    .d     (data_in),
    .msb   (sr_msb)
  );

  // Counter holds the index of the bit currently on x within its field.
  // Next-cycle x is computed here and registered, so x never sees load
  // combinationally. The shift register is shifted as its MSB is copied to
  // x, so sr_msb is always the next payload bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = 1'b0;
    fs_nxt    = 1'b0;
    fd_nxt    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    pre_sh    = '0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nxt = ST_PRE;
          cnt_nxt   = CNT_PRE;
          x_nxt     = PREAMBLE[PRE_W-1];
          fs_nxt    = 1'b1;
          sr_load   = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
          pre_sh  = PREAMBLE >> cnt_nxt;
          x_nxt   = pre_sh[0];
        end else begin
          state_nxt = ST_DATA;
          cnt_nxt   = CNT_DATA;
          x_nxt     = sr_msb;
          sr_shift  = 1'b1;
          fd_nxt    = (DATA_W == 1);
        end
      end
      ST_DATA: begin
        if (cnt != '0) begin
          cnt_nxt  = cnt - CW'(1);
          x_nxt    = sr_msb;
          sr_shift = 1'b1;
          fd_nxt   = (cnt == CW'(1));
        end else if (GAP == 0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = ST_GAP;
          cnt_nxt   = CNT_GAP;
        end
      end
      ST_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x           <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      x           <= x_nxt;
      frame_start <= fs_nxt;
      frame_done  <= fd_nxt;
    end
  end

  assign ready = (state == ST_IDLE);
  assign busy  = ~ready;
  assign Q     = state;

endmodule

// File: tb/tb_sequence_tx_101.sv
module tb_sequence_tx_101;

  logic       clk;
  logic       clear;

  logic [7:0] d8;
  logic       ld8, rdy8, x8, bsy8, fs8, fd8;
  logic [1:0] q8;

  logic [0:0] d1;
  logic       ld1, rdy1, x1, bsy1, fs1, fd1;
  logic [1:0] q1;

  int total;
  int fails;

  sequence_tx_101 #(
    .DATA_W   (8),
    .PRE_W    (3),
    .PREAMBLE (3'b101),
    .GAP      (2)
  ) dut8 (
    .clk         (clk),
    .clear       (clear),
    .data_in     (d8),
    .load        (ld8),
    .ready       (rdy8),
    .x           (x8),
    .busy        (bsy8),
    .frame_start (fs8),
    .frame_done  (fd8),
    .Q           (q8)
  );

  sequence_tx_101 #(
    .DATA_W   (1),
    .PRE_W    (3),
    .PREAMBLE (3'b101),
    .GAP      (0)
  ) dut1 (
    .clk         (clk),
    .clear       (clear),
    .data_in     (d1),
    .load        (ld1),
    .ready       (rdy1),
    .x           (x1),
    .busy        (bsy1),
    .frame_start (fs1),
    .frame_done  (fd1),
    .Q           (q1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 13-cycle frame on dut8 plus the first idle cycle after it.
  // hold: keep load high with next_data after acceptance.
  // inj: cycle at which a one-cycle load pulse with inj_data is driven.
  task automatic frame8(input string tag, input logic [7:0] data, input logic [12:0] bits,
                        input bit hold, input logic [7:0] next_data,
                        input int inj, input logic [7:0] inj_data);
    logic [1:0] qexp;
    d8  = data;
    ld8 = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      qexp = (i <= 3) ? 2'b01 : ((i <= 11) ? 2'b10 : 2'b11);
      chk($sformatf("%s_x%0d", tag, i), x8, bits[13-i]);
      chk($sformatf("%s_fs%0d", tag, i), fs8, (i == 1));
      chk($sformatf("%s_fd%0d", tag, i), fd8, (i == 11));
      chk($sformatf("%s_busy%0d", tag, i), bsy8, 1'b1);
      chk($sformatf("%s_rdy%0d", tag, i), rdy8, 1'b0);
      chk($sformatf("%s_q%0d", tag, i), q8, qexp);
      if (i == 1) begin
        ld8 = hold;
        d8  = next_data;
      end
      if (i == inj) begin
        ld8 = 1'b1;
        d8  = inj_data;
      end
      if (i == inj + 1) ld8 = 1'b0;
    end
    tick();
    chk({tag, "_rdy_end"}, rdy8, 1'b1);
    chk({tag, "_busy_end"}, bsy8, 1'b0);
    chk({tag, "_x_end"}, x8, 1'b0);
    chk({tag, "_q_end"}, q8, 2'b00);
  endtask

  initial begin
    total = 0;
    fails = 0;
    clear = 1'b0;
    d8 = '0; ld8 = 1'b0;
    d1 = '0; ld1 = 1'b0;

    // 1. reset asserted between edges, held 3 cycles
    #2 clear = 1'b1;
    #1;
    chk("rst_x", x8, 1'b0);
    chk("rst_busy", bsy8, 1'b0);
    chk("rst_rdy", rdy8, 1'b1);
    chk("rst_q", q8, 2'b00);
    chk("rst_fs", fs8, 1'b0);
    chk("rst_fd", fd8, 1'b0);
    chk("rst_rdy1", rdy1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rsth_x%0d", c), x8, 1'b0);
      chk($sformatf("rsth_rdy%0d", c), rdy8, 1'b1);
      chk($sformatf("rsth_q%0d", c), q8, 2'b00);
    end
    clear = 1'b0;
    tick();
    chk("idle_x", x8, 1'b0);
    chk("idle_rdy", rdy8, 1'b1);

    // 2. single frame A5
    frame8("a5", 8'hA5, 13'b101_10100101_00, 1'b0, 8'h00, -10, 8'h00);

    // 3. load pulse during DATA of a 00 frame is ignored
    frame8("ign", 8'h00, 13'b101_00000000_00, 1'b0, 8'h00, 6, 8'hFF);
    tick();
    chk("ign_rdy15", rdy8, 1'b1);
    chk("ign_x15", x8, 1'b0);
    chk("ign_fs15", fs8, 1'b0);

    // 4. back-to-back with load held high
    frame8("b2b0", 8'h0F, 13'b101_00001111_00, 1'b1, 8'hF0, -10, 8'h00);
    frame8("b2b1", 8'hF0, 13'b101_11110000_00, 1'b0, 8'h00, -10, 8'h00);

    // 5. async reset during 4th payload bit of an F0 frame
    d8  = 8'hF0;
    ld8 = 1'b1;
    tick();
    ld8 = 1'b0;
    chk("abort_fs", fs8, 1'b1);
    for (int c = 2; c <= 7; c++) tick();
    chk("abort_x_before", x8, 1'b1);
    chk("abort_q_before", q8, 2'b10);
    #2 clear = 1'b1;
    #1;
    chk("abort_x", x8, 1'b0);
    chk("abort_busy", bsy8, 1'b0);
    chk("abort_rdy", rdy8, 1'b1);
    chk("abort_q", q8, 2'b00);
    chk("abort_fd", fd8, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("abort_fd_h%0d", c), fd8, 1'b0);
      chk($sformatf("abort_x_h%0d", c), x8, 1'b0);
    end
    clear = 1'b0;
    tick();
    chk("abort_fd_rel", fd8, 1'b0);
    frame8("r81", 8'h81, 13'b101_10000001_00, 1'b0, 8'h00, -10, 8'h00);

    // 6. DATA_W=1, GAP=0
    d1  = 1'b1;
    ld1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) ld1 = 1'b0;
      chk($sformatf("w1_x%0d", i), x1, (i != 2));
      chk($sformatf("w1_fs%0d", i), fs1, (i == 1));
      chk($sformatf("w1_fd%0d", i), fd1, (i == 4));
      chk($sformatf("w1_rdy%0d", i), rdy1, 1'b0);
    end
    tick();
    chk("w1_rdy_end", rdy1, 1'b1);
    chk("w1_x_end", x1, 1'b0);
    chk("w1_fd_end", fd1, 1'b0);
    chk("w1_q_end", q1, 2'b00);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
